jstk_spi_responder: RTL and testbench
=====================================

# jstk_spi_responder

SPI responder that emulates the PmodJSTK joystick on the far end of the joystick SPI link. It answers the 5-byte joystick transaction from the board-side SPI master with programmable X/Y position and button state, and decodes the master's LED command byte. It serves as a bench/loopback stand-in for the physical Pmod, letting the paint pipeline run without hardware.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages in the SS/SCLK/MOSI synchronizers (minimum 2).

Ports:
- clk  in  1  system clock, 100 MHz.
- clr  in  1  reset; asynchronous assert, active-low.
- ss  in  1  slave select from master, active low.
- sclk  in  1  SPI serial clock from master, mode 0.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- x_pos  in  10  joystick X value to report.
- y_pos  in  10  joystick Y value to report.
- btn  in  3  buttons {btn2, btn1, jstk}.
- led  out  2  LED state decoded from command byte.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after a complete 40-bit frame.
- frame_err  out  1  one-cycle pulse when SS deasserts mid-frame.

## Operation
- ss, sclk, mosi pass through SYNC_STAGES-flop synchronizers, then a 1-flop edge detector.
- States: IDLE, SHIFT, DONE.
- IDLE: on synchronized ss falling edge, snapshot {x_pos, y_pos, btn} into a 40-bit tx register: byte0 = x[7:0], byte1 = {6'b0, x[9:8]}, byte2 = y[7:0], byte3 = {6'b0, y[9:8]}, byte4 = {5'b0, btn}. Present tx bit 39 on miso. Bit counter = 0. Go to SHIFT.
- SHIFT: on sclk rising edge, shift mosi into the rx register (MSB first) and increment the counter. On sclk falling edge, shift tx left and present the next bit on miso. When the counter reaches 40, go to DONE.
- DONE: wait for ss rising edge; pulse frame_done; apply LED command (see Configuration); return to IDLE.
- SHIFT with ss rising before 40 bits: pulse frame_err, discard rx, leave led unchanged, return to IDLE.
- sclk edges while ss high are ignored. Extra sclk edges in DONE are ignored, and miso holds 0.
- Inputs x_pos, y_pos, and btn may change at any time. Only the snapshot at ss fall is transmitted.
- busy is high in SHIFT and DONE.

## Timing
- Reset values: miso = 0, led = 2'b00, busy = 0, frame_done = 0, frame_err = 0, state IDLE, counter 0.
- Reset asserted mid-frame aborts immediately, with no frame_err pulse.
- Pin-to-action latency is SYNC_STAGES + 1 clk cycles.
- sclk high and low phases must each be at least SYNC_STAGES + 2 clk cycles. The nominal link (about 66.7 kHz) is far inside this limit.
- miso updates SYNC_STAGES + 1 cycles after the sclk falling edge at the pin. It is stable well before the next rising edge.
- frame_done and frame_err assert SYNC_STAGES + 1 cycles after ss rises at the pin. They are mutually exclusive.
- The master must hold ss high for at least SYNC_STAGES + 2 cycles between frames.

## Configuration
- JSTK_RESP_LED_CMD_EN defined: on frame_done, if rx byte0[7:2] == 6'b100000, led <= rx byte0[1:0]. Otherwise led holds its value.
- JSTK_RESP_LED_CMD_EN undefined: rx byte0 is ignored and led is tied to 2'b00. Received data still shifts, but is unused beyond byte counting.

## Structure
- Package jstk_pkg holds: JSTK_FRAME_BITS = 40, JSTK_LED_CMD_PREFIX = 6'b100000, the state enum, and the byte-position constants.
- One sub-module, spi_pin_sync: a parameterized synchronizer plus rise/fall detector. It is instantiated for ss, sclk, and mosi (no edge detector on mosi).

## Test plan
- Full frame: x = 10'h2A5, y = 10'h13C, btn = 3'b101. Master sends 8'h83 plus 4 dummy bytes. Required: miso bytes A5, 02, 3C, 01, 05; one frame_done pulse; led = 2'b11 (with _EN).
- Command byte 8'h03 (bad prefix) after led = 2'b11: frame_done pulses and led stays 2'b11.
- ss rises after 17 bits: frame_err pulses once, no frame_done, led unchanged, busy falls, and the next frame works normally.
- x_pos changes from 10'h000 to 10'h3FF mid-frame: transmitted bytes still 00, 00.
- Assert clr during bit 20: all outputs go to their reset values asynchronously, with no frame_err. A post-reset frame returns correct data.
- Build without JSTK_RESP_LED_CMD_EN and send 8'h82: led stays 2'b00 and frame_done still pulses.

Source files
------------

// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI responder.
package jstk_pkg;

  localparam int unsigned JSTK_FRAME_BITS     = 40;
  localparam int unsigned JSTK_CNT_W          = 6;
  localparam logic [5:0]  JSTK_LED_CMD_PREFIX = 6'b100000;

  // Command byte (byte0) position inside the 40-bit rx shift register
  localparam int unsigned JSTK_CMD_MSB = 39;
  localparam int unsigned JSTK_CMD_LSB = 32;
  // Bit presented on miso
  localparam int unsigned JSTK_TX_MSB  = 39;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } jstk_state_e;

  // Joystick reply frame, byte0 first on the wire
  typedef struct packed {
    logic [7:0] x_lo;
    logic [5:0] x_pad;
    logic [1:0] x_hi;
    logic [7:0] y_lo;
    logic [5:0] y_pad;
    logic [1:0] y_hi;
    logic [4:0] btn_pad;
    logic [2:0] btn;
  } jstk_frame_t;

  function automatic jstk_frame_t jstk_pack(input logic [9:0] x,
                                            input logic [9:0] y,
                                            input logic [2:0] b);
    jstk_frame_t f;
    f.x_lo    = x[7:0];
    f.x_pad   = 6'b0;
    f.x_hi    = x[9:8];
    f.y_lo    = y[7:0];
    f.y_pad   = 6'b0;
    f.y_hi    = y[9:8];
    f.btn_pad = 5'b0;
    f.btn     = b;
    return f;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with optional rise/fall detector.
module spi_pin_sync #(
  parameter int unsigned STAGES    = 2,
  parameter bit          RESET_VAL = 1'b0,
  parameter bit          EDGE_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;

  // Synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {STAGES{RESET_VAL}};
    else        sync_q <= {sync_q[STAGES-2:0], pin};
  end

  assign level = sync_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;

    // One-flop history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= RESET_VAL;
      else        prev_q <= level;
    end

    assign rise_c = level & ~prev_q;
    assign fall_c = ~level & prev_q;
  end else begin : g_no_edge
    assign rise_c = 1'b0;
    assign fall_c = 1'b0;
  end

endmodule

// File: rtl/jstk_spi_responder.sv
// PmodJSTK emulator: answers the 5-byte joystick SPI frame.
// Optional LED command decode enabled by defining JSTK_RESP_LED_CMD_EN.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] btn,
  output logic [1:0] led,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err
);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .EDGE_EN(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(clr), .pin(ss),
    .level(ss_lvl), .rise_c(ss_rise), .fall_c(ss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(clr), .pin(sclk),
    .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(clr), .pin(mosi),
    .level(mosi_lvl), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  jstk_state_e                state_q, state_d;
  logic [JSTK_FRAME_BITS-1:0] tx_q, tx_d;
  logic [JSTK_FRAME_BITS-1:0] rx_q, rx_d;
  logic [JSTK_CNT_W-1:0]      cnt_q, cnt_d;
  logic                       miso_d, busy_d, done_d, err_d;
  logic                       ss_lvl_unused;

  // Level of ss is implied by its edges; only edges drive the FSM
  assign ss_lvl_unused = ss_lvl ^ sclk_lvl;

  // State and datapath registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      miso       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      miso       <= miso_d;
      busy       <= busy_d;
      frame_done <= done_d;
      frame_err  <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    miso_d  = miso;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          tx_d    = JSTK_FRAME_BITS'(jstk_pack(x_pos, y_pos, btn));
          miso_d  = tx_d[JSTK_TX_MSB];
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          err_d   = 1'b1;
          rx_d    = '0;
          cnt_d   = '0;
          miso_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          rx_d  = {rx_q[JSTK_FRAME_BITS-2:0], mosi_lvl};
          cnt_d = cnt_q + JSTK_CNT_W'(1);
          if (cnt_q == JSTK_CNT_W'(JSTK_FRAME_BITS - 1)) begin
            miso_d  = 1'b0;
            state_d = ST_DONE;
          end
        end else if (sclk_fall) begin
          tx_d   = {tx_q[JSTK_FRAME_BITS-2:0], 1'b0};
          miso_d = tx_d[JSTK_TX_MSB];
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef JSTK_RESP_LED_CMD_EN
  // Latch LED command from byte0 at the end of a valid frame
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) led <= 2'b00;
    else if (done_d && (rx_q[JSTK_CMD_MSB -: 6] == JSTK_LED_CMD_PREFIX))
      led <= rx_q[JSTK_CMD_LSB +: 2];
  end
`else
  logic rx_unused;
  // Received data only paces the frame when LED decode is absent
  assign rx_unused = ^rx_q;
  assign led       = 2'b00;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Randomized self-checking bench for jstk_spi_responder acting as SPI master.
module tb_jstk_spi_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ss = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] x_pos = '0;
  logic [9:0] y_pos = '0;
  logic [2:0] btn = '0;
  logic [1:0] led;
  logic       busy, frame_done, frame_err;

  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [1:0] led_m = 2'b00;

  jstk_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .clr(clr), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .led(led), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reply frame from the byte rules using plain arithmetic
  function automatic logic [39:0] model_frame(input int x, input int y, input int b);
    int         bytes[5];
    logic [39:0] r;
    bytes[0] = x % 256;
    bytes[1] = x / 256;
    bytes[2] = y % 256;
    bytes[3] = y / 256;
    bytes[4] = b;
    r = '0;
    for (int k = 0; k < 5; k++) r = (r << 8) | 40'(bytes[k]);
    return r;
  endfunction

  task automatic run_frame(input logic [7:0] cmd, input int nbits, input int rst_at,
                           input bit chg_x, output logic [39:0] got);
    logic [39:0] mw;
    mw  = {cmd, 32'($urandom)};
    got = '0;
    @(negedge clk);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = mw[39-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      got  = {got[38:0], miso};
      if (chg_x && i == 3) x_pos = 10'h3FF;
      if (i == 10) check("busy_mid", 40'(busy), 40'd1);
      if (i == rst_at) begin
        clr = 1'b0;
        #1;
        check("rst_async_miso", 40'(miso), 40'd0);
        check("rst_async_led", 40'(led), 40'd0);
        check("rst_async_busy", 40'(busy), 40'd0);
        check("rst_async_done", 40'(frame_done), 40'd0);
        check("rst_async_err", 40'(frame_err), 40'd0);
        break;
      end
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic full_frame(input logic [7:0] cmd, input logic [9:0] x, input logic [9:0] y,
                            input logic [2:0] b, input bit chg_x, output logic [39:0] got);
    int d0, e0;
    x_pos = x;
    y_pos = y;
    btn   = b;
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(cmd, 40, -1, chg_x, got);
`ifdef JSTK_RESP_LED_CMD_EN
    if (cmd[7:2] == 6'b100000) led_m = cmd[1:0];
`endif
    check("done_pulses", 40'(done_cnt - d0), 40'd1);
    check("err_pulses", 40'(err_cnt - e0), 40'd0);
    check("led", 40'(led), 40'(led_m));
    check("busy_after", 40'(busy), 40'd0);
  endtask

  initial begin
    logic [39:0] got;
    logic [9:0]  rx, ry;
    logic [2:0]  rb;
    logic [7:0]  cmd;
    int          d0, e0;

    repeat (3) @(negedge clk);
    check("reset_miso", 40'(miso), 40'd0);
    check("reset_led", 40'(led), 40'd0);
    check("reset_busy", 40'(busy), 40'd0);
    check("reset_done", 40'(frame_done), 40'd0);
    check("reset_err", 40'(frame_err), 40'd0);
    clr = 1'b1;
    repeat (4) @(negedge clk);

    // Directed frame with LED command 3
    full_frame(8'h83, 10'h2A5, 10'h13C, 3'b101, 1'b0, got);
    check("directed_data", got, 40'hA5023C0105);

    // Bad prefix leaves LED alone
    full_frame(8'h03, 10'h155, 10'h2AA, 3'b010, 1'b0, got);
    check("badcmd_data", got, model_frame(10'h155, 10'h2AA, 3'b010));

    // Abort after 17 bits
    rx = 10'($urandom); ry = 10'($urandom); rb = 3'($urandom);
    x_pos = rx; y_pos = ry; btn = rb;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'h81, 17, -1, 1'b0, got);
    check("abort_err", 40'(err_cnt - e0), 40'd1);
    check("abort_done", 40'(done_cnt - d0), 40'd0);
    check("abort_led", 40'(led), 40'(led_m));
    check("abort_busy", 40'(busy), 40'd0);
    check("abort_partial", 40'(got[16:0]), 40'(model_frame(rx, ry, rb) >> 23));
    full_frame(8'h81, 10'h0F0, 10'h30F, 3'b111, 1'b0, got);
    check("after_abort_data", got, model_frame(10'h0F0, 10'h30F, 3'b111));

    // Inputs change after the snapshot
    full_frame(8'h00, 10'h000, 10'h000, 3'b000, 1'b1, got);
    check("snapshot_data", got, model_frame(0, 0, 0));

    // Reset asserted during bit 20
    x_pos = 10'h1AB; y_pos = 10'h0CD; btn = 3'b011;
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'h80, 40, 20, 1'b0, got);
    check("rst_no_err", 40'(err_cnt - e0), 40'd0);
    check("rst_no_done", 40'(done_cnt - d0), 40'd0);
    led_m = 2'b00;
    clr = 1'b1;
    repeat (6) @(negedge clk);
    full_frame(8'h82, 10'h1AB, 10'h0CD, 3'b011, 1'b0, got);
    check("post_rst_data", got, model_frame(10'h1AB, 10'h0CD, 3'b011));

    // Randomized frames
    for (int n = 0; n < 20; n++) begin
      rx = 10'($urandom); ry = 10'($urandom); rb = 3'($urandom);
      if ($urandom_range(0, 1) == 1) cmd = {6'b100000, 2'($urandom)};
      else                           cmd = 8'($urandom);
      full_frame(cmd, rx, ry, rb, 1'b0, got);
      check("rand_data", got, model_frame(rx, ry, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
